// File: rtl/sccb_init_sequencer_if.sv
// Start/Busy handshake bundle shared by the host request path and the SCCB
// engine. The side that issues transfers uses the master modport; the side
// that executes them uses the slave modport.
// Optional feature macro: SEQ_READBACK_EN adds the 8-bit read data return.
interface sccb_init_sequencer_if;
    logic        start;   // one-cycle transfer request
    logic [3:0]  wr;      // transfer code (4'h3 write, 4'h2 read)
    logic [31:0] data;    // {8'h00, dev_id, reg, val}
    logic        busy;    // transfer in progress
`ifdef SEQ_READBACK_EN
    logic [7:0]  rdata;   // byte returned by a completed read
`endif

`ifdef SEQ_READBACK_EN
    modport master (
        output start,
        output wr,
        output data,
        input  busy,
        input  rdata
    );

    modport slave (
        input  start,
        input  wr,
        input  data,
        output busy,
        output rdata
    );
`else
    modport master (
        output start,
        output wr,
        output data,
        input  busy
    );

    modport slave (
        input  start,
        input  wr,
        input  data,
        output busy
    );
`endif
endinterface

// File: rtl/sccb_init_sequencer.sv
// SCCB init sequencer: replays a fixed OV-sensor register table through the
// SCCB engine once the camera leaves reset, then hands the engine to the
// host path. While the table runs the host sees busy and its requests are
// dropped; in DONE or ERR the host path is passed straight through.
// Optional feature macro: SEQ_READBACK_EN (read back every written register,
// count value mismatches).
module sccb_init_sequencer #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         CLK_PER_MS  = 100000,
    parameter int         ACK_TIMEOUT = 16,
    parameter int         TBL_DEPTH   = 64,
    localparam int        PTR_W       = $clog2(TBL_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cam_ready_i,
    input  logic                         restart_i,
    sccb_init_sequencer_if.slave         host,
    sccb_init_sequencer_if.master        sccb,
    output logic                         init_done_o,
    output logic                         init_err_o,
    output logic [PTR_W-1:0]             entry_idx_o
`ifdef SEQ_READBACK_EN
    ,
    output logic [7:0]                   mismatch_cnt_o
`endif
);

    // Width of the ack timer; wide enough to hold ACK_TIMEOUT-1.
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG   = 8'hF0;
    localparam logic [3:0]  WR_CODE_WR  = 4'h3;
`ifdef SEQ_READBACK_EN
    localparam logic [3:0]  WR_CODE_RD  = 4'h2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [31:0]        delay_cnt_q;
    logic [TO_W-1:0]    ack_cnt_q;
    logic               start_q;
    logic [3:0]         wr_q;
    logic [31:0]        data_q;
    logic               done_q;
    logic               err_q;
    logic               cam_ready_q;
`ifdef SEQ_READBACK_EN
    logic               rd_phase_q;    // current transfer is the readback
    logic [7:0]         mismatch_q;
`endif

    logic [15:0]        entry_d;
    logic               is_end_d;
    logic               is_delay_d;
    logic [31:0]        delay_load_d;
    logic               restart_req_d;
    logic               host_owns_d;

    // Init table ROM: {reg, val} writes, 16'hF0nn = wait nn ms, 16'hFFFF = end.
    always_comb begin
        entry_d = ENTRY_END;
        case (ptr_q)
            PTR_W'(0): entry_d = 16'h1280;   // COM7: soft reset of all sensor registers
            PTR_W'(1): entry_d = 16'hF001;   // let the sensor settle after soft reset
            PTR_W'(2): entry_d = 16'h1101;   // CLKRC: internal clock prescaler
            PTR_W'(3): entry_d = ENTRY_END;
            default:   entry_d = ENTRY_END;
        endcase
    end

    // Entry decode; the last table slot always terminates the run so the
    // pointer can never wrap into entry 0 again.
    always_comb begin
        is_end_d     = (entry_d == ENTRY_END) || (ptr_q == PTR_W'(TBL_DEPTH - 1));
        is_delay_d   = (entry_d[15:8] == DELAY_TAG);
        delay_load_d = 32'(entry_d[7:0]) * 32'(CLK_PER_MS);
    end

    // A camera reset (cam_ready falling) re-arms the sequence like restart,
    // except once the table has completed successfully.
    always_comb begin
        restart_req_d = restart_i
                      | (cam_ready_q & ~cam_ready_i & (state_q != S_DONE));
        host_owns_d   = (state_q == S_DONE) || (state_q == S_ERR);
    end

    // Sequencer FSM with registered SCCB request and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            delay_cnt_q <= '0;
            ack_cnt_q   <= '0;
            start_q     <= 1'b0;
            wr_q        <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cam_ready_q <= 1'b0;
`ifdef SEQ_READBACK_EN
            rd_phase_q  <= 1'b0;
            mismatch_q  <= '0;
`endif
        end else begin
            cam_ready_q <= cam_ready_i;
            if (restart_req_d) begin
                // wr/data keep their last value; only the pulse is withdrawn.
                state_q     <= S_IDLE;
                ptr_q       <= '0;
                delay_cnt_q <= '0;
                start_q     <= 1'b0;
                done_q      <= 1'b0;
                err_q       <= 1'b0;
`ifdef SEQ_READBACK_EN
                rd_phase_q  <= 1'b0;
                mismatch_q  <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Also covers a transfer still in flight after restart.
                        if (cam_ready_i && !sccb.busy) begin
                            state_q <= S_FETCH;
                        end
                    end

                    S_FETCH: begin
                        if (is_end_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (is_delay_d) begin
                            delay_cnt_q <= delay_load_d;
                            state_q     <= S_DELAY;
                        end else begin
                            start_q <= 1'b1;
                            wr_q    <= WR_CODE_WR;
                            data_q  <= {8'h00, DEV_ID, entry_d};
                            state_q <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        start_q   <= 1'b0;
                        ack_cnt_q <= '0;
                        state_q   <= S_WAIT_ACK;
                    end

                    S_WAIT_ACK: begin
                        if (sccb.busy) begin
                            state_q <= S_WAIT_DONE;
                        end else if (ack_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            ack_cnt_q <= ack_cnt_q + TO_W'(1);
                        end
                    end

                    S_WAIT_DONE: begin
                        if (!sccb.busy) begin
`ifdef SEQ_READBACK_EN
                            if (!rd_phase_q) begin
                                // Same register address; the val byte is ignored on reads.
                                rd_phase_q <= 1'b1;
                                start_q    <= 1'b1;
                                wr_q       <= WR_CODE_RD;
                                state_q    <= S_ISSUE;
                            end else begin
                                rd_phase_q <= 1'b0;
                                if ((sccb.rdata != data_q[7:0]) && (mismatch_q != 8'hFF)) begin
                                    mismatch_q <= mismatch_q + 8'd1;
                                end
                                ptr_q   <= ptr_q + PTR_W'(1);
                                state_q <= S_FETCH;
                            end
`else
                            ptr_q   <= ptr_q + PTR_W'(1);
                            state_q <= S_FETCH;
`endif
                        end
                    end

                    S_DELAY: begin
                        // Counter stops at zero; the step to FETCH happens there.
                        if (delay_cnt_q == 32'd0) begin
                            ptr_q   <= ptr_q + PTR_W'(1);
                            state_q <= S_FETCH;
                        end else begin
                            delay_cnt_q <= delay_cnt_q - 32'd1;
                        end
                    end

                    S_DONE: begin
                        state_q <= S_DONE;
                    end

                    S_ERR: begin
                        state_q <= S_ERR;
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Engine ownership mux: host pass-through in DONE/ERR, sequencer otherwise.
    // A restart in the same cycle as a host request wins and drops the request.
    always_comb begin
        if (host_owns_d) begin
            sccb.start = host.start & ~restart_req_d;
            sccb.wr    = host.wr;
            sccb.data  = host.data;
            host.busy  = sccb.busy;
        end else begin
            sccb.start = start_q;
            sccb.wr    = wr_q;
            sccb.data  = data_q;
            host.busy  = 1'b1;
        end
    end

    assign init_done_o = done_q;
    assign init_err_o  = err_q;
    assign entry_idx_o = ptr_q;

`ifdef SEQ_READBACK_EN
    assign host.rdata     = sccb.rdata;
    assign mismatch_cnt_o = mismatch_q;
`endif

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Testbench for sccb_init_sequencer: scoreboard of expected SCCB requests,
// popped by a monitor on every observed sccb start pulse.
// Optional feature macro: SEQ_READBACK_EN (expects a read after each write).
module tb_sccb_init_sequencer;

    localparam int CLK_PER_MS  = 20;
    localparam int ACK_TIMEOUT = 16;
    localparam int PERIOD      = 10;
`ifdef SEQ_READBACK_EN
    localparam int XFER_PER_WR = 2;
`else
    localparam int XFER_PER_WR = 1;
`endif

    typedef struct packed {
        logic [3:0]  wr;
        logic [31:0] data;
    } xfer_t;

    logic       clk;
    logic       rstn;
    logic       cam_ready;
    logic       restart;
    logic       init_done;
    logic       init_err;
    logic [5:0] entry_idx;
`ifdef SEQ_READBACK_EN
    logic [7:0] mismatch_cnt;
`endif

    sccb_init_sequencer_if hif ();
    sccb_init_sequencer_if sif ();

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    n_starts     = 0;
    int    hb_bad       = 0;
    int    bm_mode      = 0;    // 0: engine never goes busy, 1: busy 3 cycles after start for 20 cycles
    bit    hb_watch     = 1'b0;
    bit    gap_en       = 1'b0;
    time   last_fall_t  = 0;
    xfer_t sb_q[$];

    sccb_init_sequencer #(
        .DEV_ID      (8'h42),
        .CLK_PER_MS  (CLK_PER_MS),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TBL_DEPTH   (64)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cam_ready_i    (cam_ready),
        .restart_i      (restart),
        .host           (hif),
        .sccb           (sif),
        .init_done_o    (init_done),
        .init_err_o     (init_err),
        .entry_idx_o    (entry_idx)
`ifdef SEQ_READBACK_EN
        ,
        .mismatch_cnt_o (mismatch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_xfer(input logic [3:0] wr, input logic [31:0] data);
        xfer_t x;
        x.wr   = wr;
        x.data = data;
        sb_q.push_back(x);
    endtask

    // One table write entry, plus its readback when that feature is built in.
    task automatic push_write(input logic [15:0] e);
        push_xfer(4'h3, {8'h00, 8'h42, e});
`ifdef SEQ_READBACK_EN
        push_xfer(4'h2, {8'h00, 8'h42, e});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // SCCB engine model: busy rises 3 cycles after a start and lasts 20 cycles.
    initial begin
        int  cnt;
        bit  active;
        cnt       = 0;
        active    = 1'b0;
        sif.busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (bm_mode == 1 && sif.start === 1'b1 && !active) begin
                active = 1'b1;
                cnt    = 0;
            end
            @(posedge clk);
            #1;
            if (active) begin
                cnt++;
                if (cnt == 3) sif.busy = 1'b1;
                if (cnt == 23) begin
                    sif.busy    = 1'b0;
                    active      = 1'b0;
                    last_fall_t = $time;
                end
            end
        end
    end

    // Monitor: every start pulse is matched against the scoreboard head.
    initial begin
        xfer_t exp;
        forever begin
            @(negedge clk);
            if (hb_watch && !init_done && hif.busy !== 1'b1) hb_bad++;
            if (sif.start === 1'b1) begin
                n_starts++;
                $display("[TB] start #%0d wr=%h data=%08h t=%0t", n_starts, sif.wr, sif.data, $time);
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("sb_wr", 32'(sif.wr), 32'(exp.wr));
                    chk("sb_data", sif.data, exp.data);
                end
                if (gap_en && sif.wr == 4'h3 && sif.data == 32'h00421101) begin
                    int gap;
                    gap = int'(($time - last_fall_t) / PERIOD);
                    $display("[TB] delay gap %0d cycles", gap);
                    chk("gap_ge_ms", 32'(gap >= CLK_PER_MS), 32'd1);
                end
            end
        end
    end

    // Hard stop in case a wait below is ever left unbounded.
    initial begin
        #(PERIOD * 40000);
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        int lat;
        rstn      = 1'b0;
        cam_ready = 1'b0;
        restart   = 1'b0;
        hif.start = 1'b0;
        hif.wr    = 4'h0;
        hif.data  = 32'h0;
`ifdef SEQ_READBACK_EN
        sif.rdata = 8'h00;
`endif

        // Reset state.
        repeat (3) sample();
        chk("rst_host_busy", 32'(hif.busy), 32'd1);
        chk("rst_sccb_start", 32'(sif.start), 32'd0);
        chk("rst_sccb_wr", 32'(sif.wr), 32'd0);
        chk("rst_sccb_data", sif.data, 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(init_err), 32'd0);
        chk("rst_idx", 32'(entry_idx), 32'd0);
        tick();
        rstn = 1'b1;

        // Run 1: full table, with a stray host request that must be dropped.
        push_write(16'h1280);
        push_write(16'h1101);
        bm_mode   = 1;
        hb_watch  = 1'b1;
        gap_en    = 1'b1;
        cam_ready = 1'b1;
        repeat (8) tick();
        hif.wr    = 4'h3;
        hif.data  = 32'hDEADBEEF;
        hif.start = 1'b1;
        tick();
        hif.start = 1'b0;
        for (int i = 0; i < 1000 && !init_done; i++) sample();
        hb_watch = 1'b0;
        gap_en   = 1'b0;
        chk("run1_done", 32'(init_done), 32'd1);
        chk("run1_err", 32'(init_err), 32'd0);
        chk("run1_starts", 32'(n_starts), 32'(2 * XFER_PER_WR));
        chk("run1_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("run1_host_busy_held", 32'(hb_bad), 32'd0);
        chk("run1_idx", 32'(entry_idx), 32'd3);
`ifdef SEQ_READBACK_EN
        chk("run1_mismatch", 32'(mismatch_cnt), 32'd2);
`endif

        // Host pass-through in DONE.
        tick();
        hif.wr    = 4'h2;
        hif.data  = 32'h00420A00;
        push_xfer(4'h2, 32'h00420A00);
        hif.start = 1'b1;
        sample();
        chk("pt_start", 32'(sif.start), 32'd1);
        chk("pt_wr", 32'(sif.wr), 32'h2);
        chk("pt_data", sif.data, 32'h00420A00);
        chk("pt_hbusy_idle", 32'(hif.busy), 32'd0);
        tick();
        hif.start = 1'b0;
        for (int i = 0; i < 10 && sif.busy !== 1'b1; i++) sample();
        chk("pt_mirror_hi", 32'(hif.busy), 32'd1);
        for (int i = 0; i < 40 && sif.busy !== 1'b0; i++) sample();
        chk("pt_mirror_lo", 32'(hif.busy), 32'd0);
        chk("pt_sb_empty", 32'(sb_q.size()), 32'd0);

        // Restart together with a host request in DONE: request is dropped.
        push_write(16'h1280);
        tick();
        hif.wr    = 4'h3;
        hif.data  = 32'hBADBAD00;
        hif.start = 1'b1;
        restart   = 1'b1;
        sample();
        chk("rs_host_dropped", 32'(sif.start), 32'd0);
        tick();
        hif.start = 1'b0;
        restart   = 1'b0;
        sample();
        chk("rs_done_clr", 32'(init_done), 32'd0);
        chk("rs_idx_clr", 32'(entry_idx), 32'd0);
        // Restart again while the first write is in WAIT_DONE with busy high.
        for (int i = 0; i < 60 && sif.busy !== 1'b1; i++) sample();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        ns = n_starts;
        for (int i = 0; i < 60 && sif.busy !== 1'b0; i++) sample();
        chk("rs_no_start_while_busy", 32'(n_starts), 32'(ns));
        chk("rs_sb_drained", 32'(sb_q.size()), 32'd0);
        push_write(16'h1280);
        push_write(16'h1101);
        for (int i = 0; i < 1000 && !init_done; i++) sample();
        chk("rs_done", 32'(init_done), 32'd1);
        chk("rs_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef SEQ_READBACK_EN
        chk("rs_mismatch", 32'(mismatch_cnt), 32'd2);
`endif

        // Ack timeout: engine never responds.
        bm_mode = 0;
        push_xfer(4'h3, 32'h00421280);
        ns = n_starts;
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 60 && n_starts == ns; i++) sample();
        // One ISSUE cycle, then ACK_TIMEOUT cycles of waiting for busy.
        lat = 0;
        while (!init_err && lat < 100) begin
            sample();
            lat++;
        end
        chk("to_latency", 32'(lat), 32'(ACK_TIMEOUT + 1));
        chk("to_err", 32'(init_err), 32'd1);
        chk("to_done", 32'(init_done), 32'd0);
        chk("to_sb_empty", 32'(sb_q.size()), 32'd0);

        // Host pass-through in ERR.
        tick();
        hif.wr    = 4'h3;
        hif.data  = 32'h00421234;
        push_xfer(4'h3, 32'h00421234);
        hif.start = 1'b1;
        sample();
        chk("err_pt_start", 32'(sif.start), 32'd1);
        chk("err_pt_data", sif.data, 32'h00421234);
        chk("err_hbusy", 32'(hif.busy), 32'd0);
        tick();
        hif.start = 1'b0;

        // Camera reset while in ERR behaves like restart.
        cam_ready = 1'b0;
        repeat (2) sample();
        chk("cam_fall_err_clr", 32'(init_err), 32'd0);
        chk("cam_fall_hbusy", 32'(hif.busy), 32'd1);
        chk("cam_fall_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
Controller between the APB register block and the SCCB engine. After camera reset is released, it replays a fixed table of OV-sensor register writes through the SCCB Start/Busy handshake, inserting millisecond delays where the table requests them. When the table is finished, it passes SCCB ownership to the software host path. It also arbitrates the single SCCB engine between the init table and the host.

Parameters:
- DEV_ID, 8'h42, SCCB write device address placed in DataOut[23:16].
- CLK_PER_MS, 100000, clk cycles per millisecond for delay entries.
- ACK_TIMEOUT, 16, cycles allowed for sccb_busy to rise after a start pulse.
- TBL_DEPTH, 64, table entries; pointer width is clog2(TBL_DEPTH).

Ports:
- clk  in  1  system clock (same clock as the register block and the SCCB engine).
- rstn  in  1  asynchronous active-low reset.
- cam_ready  in  1  camera out of reset (cam_rstn high); level.
- restart  in  1  one-cycle pulse that re-runs the table from entry 0.
- host_start  in  1  host request pulse (from register block Start).
- host_wr  in  4  host WR code.
- host_data  in  32  host DataOut word.
- host_busy  out  1  busy as seen by the host.
- sccb_start  out  1  start pulse to the SCCB engine.
- sccb_wr  out  4  WR code to the SCCB engine.
- sccb_data  out  32  data word to the SCCB engine.
- sccb_busy  in  1  SCCB engine Busy.
- init_done  out  1  table completed without error.
- init_err  out  1  ack timeout occurred (sticky until restart or reset).
- entry_idx  out  clog2(TBL_DEPTH)  current table pointer (debug).

Behaviour:
- Reset values:
  - All outputs 0, except host_busy = 1.
  - State IDLE; pointer 0.
- Table entry format is 16 bits {reg, val}:
  - 16'hFFFF = end marker.
  - 16'hF0nn = delay nn ms, where nn = 0 means no delay.
  - Any other value = write val to reg.
  - The table is a combinational case ROM indexed by the pointer.
  - Reaching pointer TBL_DEPTH-1 without an end marker is treated as an end marker.
- State machine:
  - IDLE: wait for cam_ready = 1, then go to FETCH.
  - FETCH (1 cycle): decode the entry.
    - End marker -> DONE.
    - Delay entry -> DELAY, load counter nn*CLK_PER_MS.
    - Write entry -> ISSUE.
  - ISSUE (1 cycle):
    - sccb_start = 1, sccb_wr = 4'h3, sccb_data = {8'h00, DEV_ID, reg, val}.
    - Go to WAIT_ACK.
  - WAIT_ACK:
    - If sccb_busy rises within ACK_TIMEOUT cycles -> WAIT_DONE.
    - Otherwise set init_err and go to ERR.
  - WAIT_DONE: on sccb_busy = 0, increment pointer and go to FETCH.
  - DELAY: decrement the counter to 0, increment pointer, go to FETCH.
  - DONE: init_done = 1; host path owns SCCB.
  - ERR: init_done = 0; host path owns SCCB so software can recover.
- Arbitration:
  - In states other than DONE and ERR:
    - host_busy = 1.
    - host_start is ignored and dropped, not queued.
    - sccb_* is driven by the sequencer.
  - In DONE and ERR:
    - sccb_start, sccb_wr and sccb_data are combinational pass-through of the host_* inputs.
    - host_busy = sccb_busy.
  - Outside ISSUE, sequencer-owned sccb_start = 0, while sccb_wr and sccb_data hold their last value.
- Restart and camera reset:
  - restart in any state:
    - Clears init_done, init_err and the pointer.
    - Goes to IDLE next cycle.
    - If an SCCB transfer is in flight (sccb_busy = 1), waits for sccb_busy = 0 before leaving IDLE.
  - cam_ready falling in any non-DONE state: same action as restart. In DONE it is ignored.
  - Simultaneous restart and host_start in DONE: restart wins; host_start is dropped.
- Delay counter is 32 bits and saturates at 0.

Optional Feature:
SEQ_READBACK_EN
- Defined:
  - Adds input sccb_rdata[7:0].
  - After each write entry's WAIT_DONE, issues a read (sccb_wr = 4'h2, same reg) and waits for it to complete.
  - Compares sccb_rdata with val.
  - Adds output mismatch_cnt[7:0], saturating at 8'hFF and cleared by restart.
  - A mismatch does not stop the sequence.
- Undefined: no read phase, no sccb_rdata or mismatch_cnt ports; timing exactly as above.

Test Plan:
- Table {0x1280, 0xF001, 0x1101, 0xFFFF}, cam_ready = 1, model Busy 3 cycles after start for 20 cycles:
  - Exactly two sccb_start pulses, with sccb_data 0x00421280 then 0x00421101.
  - Gap of at least CLK_PER_MS cycles between the first transfer's busy fall and the second start.
  - init_done = 1.
- Busy model never asserts:
  - init_err = 1 after ACK_TIMEOUT cycles.
  - State ERR; host_start passes through to sccb_start.
- host_start pulse while the table is running:
  - No extra sccb_start; host_busy = 1 throughout.
- restart mid-WAIT_DONE with sccb_busy high:
  - No new start until busy falls.
  - Table replays from entry 0 with the first data 0x00421280.
- After DONE, host_start with host_data 0x00420A00 and host_wr = 4'h2:
  - Same-cycle sccb_start with identical data and wr.
  - host_busy mirrors sccb_busy.
- With SEQ_READBACK_EN and sccb_rdata forced to 0x00:
  - Each write followed by a read.
  - mismatch_cnt = 2 at DONE for the table above.
